register_file_sb: RTL and testbench
===================================

REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 Parameter W, default 32, data width in bits.
REQ-002 Parameter A, default 3, address width; DEPTH = 2**A registers.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 WE  input  1  write enable.
REQ-006 addr_input  input  A  write address.
REQ-007 data  input  W  write data.
REQ-008 RE  input  1  read enable for both read ports.
REQ-009 addr_out1, addr_out2  input  A each  read addresses, port 1 and port 2.
REQ-010 out1, out2  output  W each  registered read data, port 1 and port 2.
REQ-011 RSV  input  1  reserve request: marks a register as awaiting a pending write.
REQ-012 addr_rsv  input  A  register to reserve.
REQ-013 busy1, busy2  output  1 each  combinational busy bit of register addr_out1 / addr_out2.
REQ-014 rsv_err  output  1  registered one-cycle pulse: reservation of an already-busy register.

Function
REQ-015 When WE=1 at an edge, register[addr_input] SHALL take data; other registers hold.
REQ-016 Reads SHALL have 1-cycle latency: when RE=1 at an edge, out1/out2 take register[addr_out1]/register[addr_out2]; when RE=0, out1/out2 hold.
REQ-017 Write-read bypass: if RE=1, WE=1 and addr_outN==addr_input in the same cycle, outN SHALL take data, not the old contents.
REQ-018 Both ports reading the same address SHALL return identical values.
REQ-019 The scoreboard SHALL hold one busy bit per register, all 0 after reset.
REQ-020 RSV=1 at an edge SHALL set busy[addr_rsv]; WE=1 at an edge SHALL clear busy[addr_input].
REQ-021 RSV and WE at the same address in one cycle: data is written and busy SHALL end at 1 (set wins).
REQ-022 RSV to a register with busy=1 (before that edge's WE clear) SHALL pulse rsv_err=1 for the next cycle; busy stays 1.
REQ-023 A write to a register with busy=0 is legal: data is written, busy stays 0, no error.
REQ-024 busy1/busy2 SHALL show the current busy bits combinationally (pre-edge), independent of RE.

Reset
REQ-025 reset=1 at an edge SHALL clear every register, out1, out2, all busy bits and rsv_err to 0.
REQ-026 Reset SHALL take priority over WE, RE and RSV in the same cycle; a reset arriving mid-reservation discards it.

Configuration
REQ-027 Macro REGFILE_ZERO_REG_EN defined: register 0 reads as 0, writes to it are ignored, RSV to it is ignored (busy[0] stays 0, no rsv_err), and the bypass SHALL NOT forward to address 0.
REQ-028 Macro REGFILE_ZERO_REG_EN undefined: register 0 is an ordinary register.

Structure
REQ-029 Package regfile_pkg SHALL hold the default constants for W and A and the DEPTH derivation.
REQ-030 Busy-bit logic SHALL be a separate sub-module, regfile_scoreboard (inputs RSV/addr_rsv/WE/addr_input; outputs busy vector and rsv_err).
REQ-031 Storage SHALL be one W-bit register per entry with a per-entry write enable from a one-hot decode of addr_input.

Verification
REQ-032 Write 0xDEADBEEF to r5, then RE=1 with addr_out1=5 -> out1=0xDEADBEEF one cycle later; out2 unchanged while RE=0.
REQ-033 Same cycle WE=1, addr_input=3, data=0x12345678, RE=1, addr_out1=addr_out2=3 -> next cycle out1=out2=0x12345678.
REQ-034 RSV r2 -> busy1=1 with addr_out1=2; second RSV r2 -> rsv_err=1 for exactly one cycle; WE r2 -> busy1=0 the following cycle.
REQ-035 Same cycle RSV r4 and WE r4 with data=0xA5 -> r4=0xA5 and busy[4]=1.
REQ-036 Fill all registers with index values, then reset=1 together with WE=1 -> all reads return 0, busy all 0, rsv_err=0.
REQ-037 With REGFILE_ZERO_REG_EN: WE r0 data=0xFFFFFFFF with RE=1, addr_out1=0 -> out1=0; RSV r0 -> busy1=0 and rsv_err=0.

Source files
------------

// File: rtl/register_file_sb_pkg.sv
// Shared sizing constants for the register file with busy-bit scoreboard.
// DEPTH is always derived from the address width.
package regfile_pkg;

  localparam int W_DEFAULT = 32;
  localparam int A_DEFAULT = 3;

  function automatic int depth_of(input int a);
    return 1 << a;
  endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Write, read and reserve bus of the register file; master drives requests, slave returns data/busy.
// No flow control: every request is accepted on the edge it is presented.
interface register_file_sb_if #(
  parameter int W = 32,
  parameter int A = 3
);

  logic         WE;
  logic [A-1:0] addr_input;
  logic [W-1:0] data;
  logic         RE;
  logic [A-1:0] addr_out1;
  logic [A-1:0] addr_out2;
  logic [W-1:0] out1;
  logic [W-1:0] out2;
  logic         RSV;
  logic [A-1:0] addr_rsv;
  logic         busy1;
  logic         busy2;
  logic         rsv_err;

  modport master (
    output WE, addr_input, data, RE, addr_out1, addr_out2, RSV, addr_rsv,
    input  out1, out2, busy1, busy2, rsv_err
  );

  modport slave (
    input  WE, addr_input, data, RE, addr_out1, addr_out2, RSV, addr_rsv,
    output out1, out2, busy1, busy2, rsv_err
  );

endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Per-register busy bits: RSV sets, WE clears, set wins on a same-address collision; rsv_err flags re-reserving.
// Latency: busy updates on the edge, rsv_err is a registered 1-cycle pulse. Optional REGFILE_ZERO_REG_EN masks register 0.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int A     = A_DEFAULT,
  parameter int DEPTH = depth_of(A)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RSV,
  input  logic [A-1:0]     addr_rsv,
  input  logic             WE,
  input  logic [A-1:0]     addr_input,
  output logic [DEPTH-1:0] busy,
  output logic             rsv_err
);

  logic             rsv_ok;
  logic             rsv_err_d;
  logic [DEPTH-1:0] busy_next;

`ifdef REGFILE_ZERO_REG_EN
  assign rsv_ok = RSV && (addr_rsv != '0);
`else
  assign rsv_ok = RSV;
`endif

  // Error looks at the busy bit before this edge's write clear.
  assign rsv_err_d = rsv_ok && busy[addr_rsv];

  always_comb begin
    busy_next = busy;
    if (WE) busy_next[addr_input] = 1'b0;
    if (rsv_ok) busy_next[addr_rsv] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= '0;
      rsv_err <= 1'b0;
    end else begin
      busy    <= busy_next;
      rsv_err <= rsv_err_d;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// 2-read/1-write register file with write-to-read bypass and a busy-bit scoreboard; REGFILE_ZERO_REG_EN hardwires r0 to 0.
// Reads have 1-cycle latency when RE=1 and hold otherwise; busy1/busy2 are combinational; no backpressure.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int A = A_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  register_file_sb_if.slave bus
);

  localparam int DEPTH = depth_of(A);

  logic             wr_ok;
  logic [DEPTH-1:0] wr_en;
  logic [W-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             byp1;
  logic             byp2;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_ok = bus.WE && (bus.addr_input != '0);
`else
  assign wr_ok = bus.WE;
`endif

  // wr_ok already excludes r0 when it is hardwired, so the bypass never forwards to it.
  assign byp1 = wr_ok && (bus.addr_out1 == bus.addr_input);
  assign byp2 = wr_ok && (bus.addr_out2 == bus.addr_input);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign wr_en[i] = wr_ok && (bus.addr_input == A'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (wr_en[i]) begin
        regs[i] <= bus.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out1 <= '0;
      bus.out2 <= '0;
    end else if (bus.RE) begin
      bus.out1 <= byp1 ? bus.data : regs[bus.addr_out1];
      bus.out2 <= byp2 ? bus.data : regs[bus.addr_out2];
    end
  end

  regfile_scoreboard #(
    .A     (A),
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .RSV        (bus.RSV),
    .addr_rsv   (bus.addr_rsv),
    .WE         (bus.WE),
    .addr_input (bus.addr_input),
    .busy       (busy),
    .rsv_err    (bus.rsv_err)
  );

  assign bus.busy1 = busy[bus.addr_out1];
  assign bus.busy2 = busy[bus.addr_out2];

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed scenarios plus random traffic against an array-based model.
// Build with REGFILE_ZERO_REG_EN defined to exercise the hardwired-r0 variant.
module tb_register_file_sb;

  localparam int W     = 32;
  localparam int A     = 3;
  localparam int DEPTH = 1 << A;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  register_file_sb_if #(.W(W), .A(A)) bus ();

  register_file_sb #(.W(W), .A(A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: what each register, busy bit and output should hold.
  logic [W-1:0] m_mem [DEPTH];
  bit           m_busy [DEPTH];
  logic [W-1:0] m_out1;
  logic [W-1:0] m_out2;
  bit           m_err;
  bit           m_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    reset          = 1'b0;
    bus.WE         = 1'b0;
    bus.addr_input = '0;
    bus.data       = '0;
    bus.RE         = 1'b0;
    bus.addr_out1  = '0;
    bus.addr_out2  = '0;
    bus.RSV        = 1'b0;
    bus.addr_rsv   = '0;
  endtask

  function automatic bit is_zero_reg(input logic [A-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Inputs are already driven; check busy pre-edge, advance the model, clock, check outputs.
  task automatic tick();
    bit wr;
    bit rsv;
    #1;
    if (m_valid) begin
      check_eq("busy1", W'(bus.busy1), W'(m_busy[bus.addr_out1]));
      check_eq("busy2", W'(bus.busy2), W'(m_busy[bus.addr_out2]));
    end
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_out1  = '0;
      m_out2  = '0;
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else begin
      wr  = bus.WE && !is_zero_reg(bus.addr_input);
      rsv = bus.RSV && !is_zero_reg(bus.addr_rsv);
      if (bus.RE) begin
        m_out1 = (wr && bus.addr_out1 == bus.addr_input) ? bus.data : m_mem[bus.addr_out1];
        m_out2 = (wr && bus.addr_out2 == bus.addr_input) ? bus.data : m_mem[bus.addr_out2];
      end
      m_err = rsv && m_busy[bus.addr_rsv];
      if (wr) m_mem[bus.addr_input] = bus.data;
      if (bus.WE) m_busy[bus.addr_input] = 1'b0;
      if (rsv) m_busy[bus.addr_rsv] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("out1", bus.out1, m_out1);
    check_eq("out2", bus.out2, m_out2);
    check_eq("rsv_err", W'(bus.rsv_err), W'(m_err));
  endtask

  initial begin
    set_idle();
    @(negedge clk);

    // Reset state
    reset = 1'b1;
    tick();
    set_idle();
    tick();
    check_eq("rst_out1", bus.out1, '0);
    check_eq("rst_err", W'(bus.rsv_err), '0);

    // Write r5, read it on port 1 only, then hold with RE=0
    bus.WE = 1'b1; bus.addr_input = 3'd5; bus.data = 32'hDEADBEEF;
    tick();
    set_idle();
    bus.RE = 1'b1; bus.addr_out1 = 3'd5; bus.addr_out2 = 3'd1;
    tick();
    check_eq("r5_read", bus.out1, 32'hDEADBEEF);
    check_eq("r1_read", bus.out2, '0);
    set_idle();
    bus.addr_out1 = 3'd2; bus.addr_out2 = 3'd5;
    tick();
    check_eq("hold_out1", bus.out1, 32'hDEADBEEF);
    check_eq("hold_out2", bus.out2, '0);

    // Same-cycle write and dual read of r3 must bypass
    set_idle();
    bus.WE = 1'b1; bus.addr_input = 3'd3; bus.data = 32'h12345678;
    bus.RE = 1'b1; bus.addr_out1 = 3'd3; bus.addr_out2 = 3'd3;
    tick();
    check_eq("byp_out1", bus.out1, 32'h12345678);
    check_eq("byp_out2", bus.out2, 32'h12345678);

    // Reserve r2, re-reserve (error pulse), then release by write
    set_idle();
    bus.RSV = 1'b1; bus.addr_rsv = 3'd2; bus.addr_out1 = 3'd2;
    tick();
    #1;
    check_eq("rsv_busy1", W'(bus.busy1), 32'd1);
    tick();
    check_eq("rsv_err_hi", W'(bus.rsv_err), 32'd1);
    set_idle();
    bus.addr_out1 = 3'd2;
    tick();
    check_eq("rsv_err_lo", W'(bus.rsv_err), '0);
    bus.WE = 1'b1; bus.addr_input = 3'd2; bus.data = 32'h0000_0022;
    tick();
    set_idle();
    bus.addr_out1 = 3'd2;
    #1;
    check_eq("rel_busy1", W'(bus.busy1), '0);

    // Reserve and write r4 together: data lands, busy stays set
    set_idle();
    bus.RSV = 1'b1; bus.addr_rsv = 3'd4;
    bus.WE = 1'b1; bus.addr_input = 3'd4; bus.data = 32'h0000_00A5;
    tick();
    set_idle();
    bus.RE = 1'b1; bus.addr_out1 = 3'd4; bus.addr_out2 = 3'd4;
    tick();
    check_eq("r4_data", bus.out1, 32'h0000_00A5);
    #1;
    check_eq("r4_busy", W'(bus.busy1), 32'd1);

`ifdef REGFILE_ZERO_REG_EN
    // r0 is hardwired: no write, no bypass, no reservation
    set_idle();
    bus.WE = 1'b1; bus.addr_input = 3'd0; bus.data = 32'hFFFFFFFF;
    bus.RE = 1'b1; bus.addr_out1 = 3'd0;
    tick();
    check_eq("z_out1", bus.out1, '0);
    set_idle();
    bus.RSV = 1'b1; bus.addr_rsv = 3'd0; bus.addr_out1 = 3'd0;
    tick();
    tick();
    check_eq("z_err", W'(bus.rsv_err), '0);
    #1;
    check_eq("z_busy1", W'(bus.busy1), '0);
`endif

    // Fill with index values, reserve a few, then reset alongside a write
    for (int i = 0; i < DEPTH; i++) begin
      set_idle();
      bus.WE = 1'b1; bus.addr_input = A'(i); bus.data = W'(i);
      bus.RSV = 1'b1; bus.addr_rsv = A'(DEPTH - 1 - i);
      tick();
    end
    set_idle();
    reset = 1'b1; bus.WE = 1'b1; bus.addr_input = 3'd6; bus.data = 32'hCAFEF00D;
    bus.RE = 1'b1; bus.RSV = 1'b1; bus.addr_rsv = 3'd1;
    tick();
    for (int i = 0; i < DEPTH; i += 2) begin
      set_idle();
      bus.RE = 1'b1; bus.addr_out1 = A'(i); bus.addr_out2 = A'(i + 1);
      tick();
      check_eq("clr_out1", bus.out1, '0);
      check_eq("clr_out2", bus.out2, '0);
      check_eq("clr_err", W'(bus.rsv_err), '0);
      #1;
      check_eq("clr_busy", W'({bus.busy1, bus.busy2}), '0);
    end

    // Random traffic, with narrow addresses on some cycles to force collisions
    for (int n = 0; n < 400; n++) begin
      set_idle();
      reset          = ($urandom_range(0, 63) == 0);
      bus.WE         = $urandom_range(0, 1);
      bus.RE         = $urandom_range(0, 1);
      bus.RSV        = ($urandom_range(0, 2) == 0);
      bus.data       = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        bus.addr_input = A'($urandom_range(0, 1));
        bus.addr_out1  = A'($urandom_range(0, 1));
        bus.addr_out2  = A'($urandom_range(0, 1));
        bus.addr_rsv   = A'($urandom_range(0, 1));
      end else begin
        bus.addr_input = A'($urandom);
        bus.addr_out1  = A'($urandom);
        bus.addr_out2  = A'($urandom);
        bus.addr_rsv   = A'($urandom);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
